// File: rtl/tensor_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tensor_write_sequencer
// Description : Accepts packed 4-channel int8 result words over a valid/ready
//               handshake and streams them into the tensor RAM one byte per
//               cycle, generating row/col/channel coordinates in row-major,
//               channel-last order. Pulses done after the last byte of a
//               num_rows x num_cols x num_channels tensor has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module tensor_write_sequencer #(
  parameter int MAX_N      = 64,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int MAX_NUM_CH = 64,
  parameter int CH_BITS    = $clog2(MAX_NUM_CH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_BITS-1:0]  cfg_num_rows,
  input  logic [N_BITS-1:0]  cfg_num_cols,
  input  logic [CH_BITS-1:0] cfg_num_channels,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               write_en,
  output logic [N_BITS-1:0]  write_row,
  output logic [N_BITS-1:0]  write_col,
  output logic [CH_BITS-1:0] write_channel,
  output logic [N_BITS-1:0]  num_cols,
  output logic [CH_BITS-1:0] num_channels,
  output logic [7:0]         data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched tensor geometry
  logic [N_BITS-1:0]  rows_q,  rows_d;
  logic [N_BITS-1:0]  cols_q,  cols_d;
  logic [CH_BITS-1:0] chans_q, chans_d;

  // Coordinate of the next byte to be emitted
  logic [N_BITS-1:0]  row_q, row_d;
  logic [N_BITS-1:0]  col_q, col_d;
  logic [CH_BITS-1:0] ch_q,  ch_d;

  // Holding register: the word whose lane lane_q is currently on the RAM port
  logic [31:0]        word_q, word_d;
  logic [1:0]         lane_q, lane_d;

  // Registered RAM write port
  logic               we_q,   we_d;
  logic [N_BITS-1:0]  wrow_q, wrow_d;
  logic [N_BITS-1:0]  wcol_q, wcol_d;
  logic [CH_BITS-1:0] wch_q,  wch_d;
  logic [7:0]         data_q, data_d;

  // Combinational helpers
  logic               last_lane;
  logic               final_byte;
  logic               accept;
  logic               cfg_zero;
  logic [1:0]         next_lane;
  logic               emit;
  logic [7:0]         emit_byte;

  // The byte currently on the port closes its word when it is lane 3 or the
  // last channel of the pixel; the next word may be taken in that same cycle,
  // which is what keeps back-to-back words bubble-free.
  assign last_lane  = we_q && ((lane_q == 2'd3) ||
                               (wch_q == chans_q - CH_BITS'(1)));

  // The byte on the port is the very last byte of the tensor.
  assign final_byte = we_q &&
                      (wrow_q == rows_q  - N_BITS'(1))  &&
                      (wcol_q == cols_q  - N_BITS'(1))  &&
                      (wch_q  == chans_q - CH_BITS'(1));

  assign in_ready  = (state_q == ST_RUN) && (!we_q || last_lane) && !final_byte;
  assign accept    = in_valid && in_ready;
  assign next_lane = lane_q + 2'd1;
  assign cfg_zero  = (cfg_num_rows == '0) || (cfg_num_cols == '0) ||
                     (cfg_num_channels == '0);

  // Next-state, byte emission and coordinate advance
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    chans_d   = chans_q;
    row_d     = row_q;
    col_d     = col_q;
    ch_d      = ch_q;
    word_d    = word_q;
    lane_d    = lane_q;
    we_d      = 1'b0;
    wrow_d    = wrow_q;
    wcol_d    = wcol_q;
    wch_d     = wch_q;
    data_d    = data_q;
    emit      = 1'b0;
    emit_byte = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_d  = cfg_num_rows;
          cols_d  = cfg_num_cols;
          chans_d = cfg_num_channels;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
          state_d = cfg_zero ? ST_FIN : ST_RUN;
        end
      end

      ST_RUN: begin
        if (final_byte) begin
          state_d = ST_FIN;
        end else if (we_q && !last_lane) begin
          // Continue with the next lane of the held word.
          emit      = 1'b1;
          lane_d    = next_lane;
          emit_byte = word_q[{next_lane, 3'b000} +: 8];
        end else if (accept) begin
          // New word: its lane 0 goes straight onto the port.
          emit      = 1'b1;
          word_d    = in_data;
          lane_d    = 2'd0;
          emit_byte = in_data[7:0];
        end

        if (emit) begin
          we_d   = 1'b1;
          wrow_d = row_q;
          wcol_d = col_q;
          wch_d  = ch_q;
          data_d = emit_byte;
          if (ch_q == chans_q - CH_BITS'(1)) begin
            ch_d = '0;
            if (col_q == cols_q - N_BITS'(1)) begin
              col_d = '0;
              row_d = row_q + N_BITS'(1);
            end else begin
              col_d = col_q + N_BITS'(1);
            end
          end else begin
            ch_d = ch_q + CH_BITS'(1);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      chans_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wch_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      chans_q <= chans_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      wch_q   <= wch_d;
      data_q  <= data_d;
    end
  end

  assign write_en      = we_q;
  assign write_row     = wrow_q;
  assign write_col     = wcol_q;
  assign write_channel = wch_q;
  assign data_out      = data_q;
  assign num_cols      = cols_q;
  assign num_channels  = chans_q;
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_tensor_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tensor_write_sequencer
// Description : Self-checking bench for tensor_write_sequencer. A reference
//               model expands the word stream into the expected byte list and
//               predicts handshake/strobe timing cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tensor_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cfg_num_rows;
  logic [5:0]  cfg_num_cols;
  logic [6:0]  cfg_num_channels;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        write_en;
  logic [5:0]  write_row;
  logic [5:0]  write_col;
  logic [6:0]  write_channel;
  logic [5:0]  num_cols;
  logic [6:0]  num_channels;
  logic [7:0]  data_out;
  logic        busy;
  logic        done;

  tensor_write_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_num_rows     (cfg_num_rows),
    .cfg_num_cols     (cfg_num_cols),
    .cfg_num_channels (cfg_num_channels),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .write_en         (write_en),
    .write_row        (write_row),
    .write_col        (write_col),
    .write_channel    (write_channel),
    .num_cols         (num_cols),
    .num_channels     (num_channels),
    .data_out         (data_out),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int r;
    int c;
    int ch;
    int data;
  } wr_t;

  typedef struct {
    int r, c, ch, mode, pat, poke;
    int exp_n, exp_lr, exp_lc, exp_lch;
  } vec_t;

  logic [31:0] wq[$];
  wr_t         expq[$];
  int          cap_data[$];

  // Word stream for a tensor: pat 0 random, 1 byte = linear index,
  // 2 byte = linear index + 1. Unused upper lanes carry junk.
  task automatic build_words(input int r, input int c, input int ch, input int pat);
    int ng;
    int b;
    logic [31:0] w;
    wq.delete();
    ng = (ch + 3) / 4;
    for (int p = 0; p < r * c; p++) begin
      for (int g = 0; g < ng; g++) begin
        w = $urandom;
        for (int l = 0; l < 4; l++) begin
          if (g * 4 + l < ch) begin
            if (pat == 0)      b = $urandom_range(0, 255);
            else if (pat == 1) b = (p * ch + g * 4 + l) & 255;
            else               b = (p * ch + g * 4 + l + 1) & 255;
            w[l*8 +: 8] = 8'(b);
          end
        end
        wq.push_back(w);
      end
    end
  endtask

  // Expected writes: every byte of the tensor in row-major channel-last order,
  // taken from word (pixel * groups + channel / 4), lane channel % 4.
  task automatic build_expect(input int r, input int c, input int ch);
    int ng;
    wr_t e;
    logic [31:0] w;
    expq.delete();
    ng = (ch + 3) / 4;
    for (int p = 0; p < r * c; p++) begin
      for (int cc = 0; cc < ch; cc++) begin
        w      = wq[p * ng + cc / 4];
        e.r    = p / c;
        e.c    = p % c;
        e.ch   = cc;
        e.data = int'((w >> (8 * (cc % 4))) & 32'hFF);
        expq.push_back(e);
      end
    end
  endtask

  // Runs one tensor from start to done, checking every cycle.
  // mode: 0 valid always, 1 valid toggles, 2 random valid.
  task automatic run_tensor(input int r, input int c, input int ch, input int mode,
                            input int poke, output int nwr, output int lr,
                            output int lc, output int lch);
    int  widx = 0;
    int  cyc = 0;
    bit  xfer_prev = 0, we_prev = 0, last_prev = 0, fin_prev = 0;
    bit  running = 1, ended = 0;
    bit  lastl, fin, v, xfer;
    wr_t e;
    build_expect(r, c, ch);
    nwr = 0; lr = -1; lc = -1; lch = -1;
    cap_data.delete();
    @(negedge clk);
    start            = 1'b1;
    cfg_num_rows     = 6'(r);
    cfg_num_cols     = 6'(c);
    cfg_num_channels = 7'(ch);
    in_valid         = 1'b0;
    in_data          = $urandom;
    @(negedge clk);
    start = 1'b0;
    while (!ended && cyc < 3000) begin
      lastl = 0;
      fin   = 0;
      chk("write_en", int'(write_en), int'(xfer_prev || (we_prev && !last_prev)));
      if (write_en) begin
        nwr++;
        lr = write_row; lc = write_col; lch = write_channel;
        cap_data.push_back(int'(data_out));
        if (expq.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("write_row", int'(write_row), e.r);
          chk("write_col", int'(write_col), e.c);
          chk("write_channel", int'(write_channel), e.ch);
          chk("data_out", int'(data_out), e.data);
          lastl = (e.ch % 4 == 3) || (e.ch == ch - 1);
          fin   = (expq.size() == 0);
        end
      end
      chk("done", int'(done), int'(fin_prev));
      if (fin_prev) begin
        running = 0;
        ended   = 1;
      end
      chk("busy", int'(busy), int'(running));
      chk("in_ready", int'(in_ready), int'(running && (!write_en || lastl) && !fin));
      if (!ended) begin
        start = 1'b0;
        if (poke != 0 && cyc == 3) begin
          start            = 1'b1;
          cfg_num_rows     = 6'd5;
          cfg_num_cols     = 6'd5;
          cfg_num_channels = 7'd9;
        end
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (widx >= wq.size()) v = 1'b0;
        in_valid = v;
        in_data  = v ? wq[widx] : $urandom;
        xfer     = in_valid && in_ready;
        if (xfer) widx++;
        we_prev   = write_en;
        last_prev = lastl;
        fin_prev  = fin;
        xfer_prev = xfer;
        cyc++;
        @(negedge clk);
      end
    end
    if (!ended) chk("timeout_waiting_done", 1, 0);
    in_valid = 1'b0;
    start    = 1'b0;
    chk("num_cols_latched", int'(num_cols), c);
    chk("num_channels_latched", int'(num_channels), ch);
    chk("unwritten_bytes", expq.size(), 0);
    @(negedge clk);
    chk("done_single_cycle", int'(done), 0);
    chk("write_en_after_done", int'(write_en), 0);
  endtask

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, lr, lc, lch, wcount, widx, r, c, ch;
    int zc[3][3];

    tbl[0] = '{1, 2, 4,  0, 2, 0,   8,  0, 1, 3};
    tbl[1] = '{2, 2, 5,  2, 0, 0,  20,  1, 1, 4};
    tbl[2] = '{1, 2, 8,  1, 1, 0,  16,  0, 1, 7};
    tbl[3] = '{3, 1, 1,  2, 0, 0,   3,  2, 0, 0};
    tbl[4] = '{1, 1, 64, 0, 1, 1,  64,  0, 0, 63};
    tbl[5] = '{2, 3, 7,  2, 0, 1,  42,  1, 2, 6};
    tbl[6] = '{2, 3, 64, 0, 1, 0, 384,  1, 2, 63};
    tbl[7] = '{63, 1, 2, 2, 0, 0, 126, 62, 0, 1};

    reset            = 1'b1;
    start            = 1'b0;
    in_valid         = 1'b0;
    in_data          = '0;
    cfg_num_rows     = '0;
    cfg_num_cols     = '0;
    cfg_num_channels = '0;
    repeat (3) @(negedge clk);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_num_cols", int'(num_cols), 0);
    chk("rst_num_channels", int'(num_channels), 0);
    reset = 1'b0;

    // Table-driven tensors
    for (int i = 0; i < 8; i++) begin
      build_words(tbl[i].r, tbl[i].c, tbl[i].ch, tbl[i].pat);
      run_tensor(tbl[i].r, tbl[i].c, tbl[i].ch, tbl[i].mode, tbl[i].poke,
                 nwr, lr, lc, lch);
      chk("n_writes", nwr, tbl[i].exp_n);
      chk("last_row", lr, tbl[i].exp_lr);
      chk("last_col", lc, tbl[i].exp_lc);
      chk("last_channel", lch, tbl[i].exp_lch);
      if (i == 0) begin
        for (int k = 0; k < 8; k++)
          chk("basic_byte", (k < cap_data.size()) ? cap_data[k] : -1, k + 1);
      end
    end

    // Partial group: upper lane of each word must be dropped
    wq.delete();
    wq.push_back(32'hAA030201);
    wq.push_back(32'hBB060504);
    run_tensor(1, 2, 3, 0, 0, nwr, lr, lc, lch);
    chk("partial_n_writes", nwr, 6);
    for (int k = 0; k < 6; k++)
      chk("partial_byte", (k < cap_data.size()) ? cap_data[k] : -1, k + 1);

    // Zero-sized starts: done one cycle later, nothing written
    zc[0] = '{0, 2, 4};
    zc[1] = '{1, 0, 4};
    zc[2] = '{1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start            = 1'b1;
      cfg_num_rows     = 6'(zc[i][0]);
      cfg_num_cols     = 6'(zc[i][1]);
      cfg_num_channels = 7'(zc[i][2]);
      in_valid         = 1'b1;
      in_data          = $urandom;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", int'(done), 1);
      chk("zero_write_en", int'(write_en), 0);
      chk("zero_busy", int'(busy), 0);
      chk("zero_in_ready", int'(in_ready), 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("zero_done_cleared", int'(done), 0);
      chk("zero_write_en_after", int'(write_en), 0);
    end

    // Reset after 3 of 8 bytes
    build_words(1, 2, 8, 1);
    widx   = 0;
    wcount = 0;
    @(negedge clk);
    start            = 1'b1;
    cfg_num_rows     = 6'd1;
    cfg_num_cols     = 6'd2;
    cfg_num_channels = 7'd8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && wcount < 3; k++) begin
      if (write_en) wcount++;
      if (wcount < 3) begin
        in_valid = (widx < wq.size());
        in_data  = in_valid ? wq[widx] : 32'h0;
        if (in_valid && in_ready) widx++;
        @(negedge clk);
      end
    end
    chk("reset_setup_writes", wcount, 3);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_write_en", int'(write_en), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_row", int'(write_row), 0);
    chk("midrst_col", int'(write_col), 0);
    chk("midrst_channel", int'(write_channel), 0);
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_num_cols", int'(num_cols), 0);
    chk("midrst_num_channels", int'(num_channels), 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_no_done", int'(done), 0);
      chk("postrst_no_write", int'(write_en), 0);
    end
    build_words(1, 2, 8, 1);
    run_tensor(1, 2, 8, 0, 0, nwr, lr, lc, lch);
    chk("restart_n_writes", nwr, 16);

    // Randomized tensors against the model
    for (int i = 0; i < 6; i++) begin
      r  = $urandom_range(1, 4);
      c  = $urandom_range(1, 4);
      ch = $urandom_range(1, 12);
      build_words(r, c, ch, 0);
      run_tensor(r, c, ch, 2, 0, nwr, lr, lc, lch);
      chk("rand_n_writes", nwr, r * c * ch);
      chk("rand_last_row", lr, r - 1);
      chk("rand_last_col", lc, c - 1);
      chk("rand_last_channel", lch, ch - 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tensor_write_sequencer.md
Name: tensor_write_sequencer

Overview:
- Upstream writer for the tensor RAM. Accepts packed 4-channel int8 result words from the output path over a valid/ready handshake.
- Serializes each word to one byte per cycle and drives the RAM byte-write port with row/col/channel coordinates in row-major, channel-last order.
- Tracks a full output tensor of num_rows x num_cols x num_channels and pulses done after the last byte is written.

Parameters:
- MAX_N, 64, max rows/cols of the output tensor
- N_BITS, $clog2(MAX_N), row/col coordinate width
- MAX_NUM_CH, 64, max channel count
- CH_BITS, $clog2(MAX_NUM_CH+1), channel count/index width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin a tensor; config inputs sampled on this cycle
- cfg_num_rows  input  N_BITS  tensor rows
- cfg_num_cols  input  N_BITS  tensor columns
- cfg_num_channels  input  CH_BITS  channels per pixel
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer accepts in_data this cycle
- in_data  input  32  four int8 channels; [7:0] is lowest channel of the group
- write_en  output  1  RAM byte write strobe
- write_row  output  N_BITS  RAM row coordinate
- write_col  output  N_BITS  RAM column coordinate
- write_channel  output  CH_BITS  RAM channel coordinate
- num_cols  output  N_BITS  latched cfg_num_cols, to RAM
- num_channels  output  CH_BITS  latched cfg_num_channels, to RAM
- data_out  output  8  byte to RAM data_in
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high.
- Reset values: all outputs 0; FSM IDLE; holding register empty.
- Reset mid-operation: return to IDLE next edge. Partially emitted words are discarded. No done pulse.
- FSM IDLE:
  - start=1 latches the config.
  - If any of rows/cols/channels is 0, go to FIN and write nothing.
  - Otherwise go to RUN.
  - start is ignored outside IDLE.
- FSM RUN:
  - Coordinate counters row/col/ch start at 0.
  - Holding register stores one word plus lane index 0..3.
  - Lane count per word = min(4, num_channels - group_base), where group_base is the channel of lane 0. Unused upper lanes are dropped.
  - A word may not straddle pixels.
- Handshake:
  - in_ready = RUN and (holding empty, or the current lane is the last valid lane of the held word) and not all bytes emitted.
  - Transfer occurs when in_valid and in_ready.
  - in_data is ignored when in_ready=0.
- Latency and throughput:
  - A word accepted at edge N produces write_en=1 for lane 0 in cycle N+1, with data_out=in_data[7:0].
  - Lanes follow on consecutive cycles.
  - Back-to-back words give write_en=1 every cycle with no bubble.
  - write_en=0 in any cycle with no byte to emit.
- Counter advance per emitted byte:
  - If ch == num_channels-1: ch=0, then col advances.
  - If col == num_cols-1: col=0, then row advances.
  - Increments use CH_BITS/N_BITS arithmetic; no wrap is reachable within legal config.
- Completion: when the byte at row=num_rows-1, col=num_cols-1, ch=num_channels-1 is emitted, FSM goes to FIN. in_ready is forced 0 from that cycle.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy: 1 in RUN, 0 in IDLE and FIN.
- RAM port outputs: write_row/col/channel and data_out are registered with write_en and are valid only while write_en=1. num_cols/num_channels hold their latched values until the next start.

Test Plan:
- Basic write:
  - Stimulus: reset, then start with rows=1, cols=2, ch=4; words 0x04030201 then 0x08070605, in_valid held high.
  - Response: 8 consecutive write_en cycles with (row,col,ch,data) = (0,0,0,01)..(0,0,3,04),(0,1,0,05)..(0,1,3,08); done pulses one cycle after the last write; busy then 0.
- Partial group:
  - Stimulus: rows=1, cols=2, ch=3; words 0xAA030201 and 0xBB060504.
  - Response: 6 writes; channels 0,1,2 per pixel; bytes AA and BB never written.
- Backpressure and bubbles:
  - Stimulus: ch=8, in_valid toggled 1/0 each cycle.
  - Response: in_ready=0 during lanes 0-2 of each held word; write_en gaps match the input gaps; coordinates stay contiguous; no byte lost or duplicated.
- Zero and illegal starts:
  - Stimulus: start with cols=0.
  - Response: no write_en, done one cycle later.
  - Stimulus: start pulsed during RUN.
  - Response: ignored; config unchanged.
- Reset mid-operation:
  - Stimulus: assert reset after 3 of 8 bytes.
  - Response: next cycle all outputs 0, in_ready=0, no done. A new start restarts at (0,0,0).
- Full-size tensor:
  - Stimulus: rows=2, cols=3, ch=64; 96 words streamed, each byte = low 8 bits of its linear index.
  - Response: 384 writes; last write at (1,2,63); write_row*3*64 + write_col*64 + write_channel equals the byte index for every write.
